// File: rtl/multi_channel_xor_cipher_if.sv
// Beat handshake bundle for multi_channel_xor_cipher: input beat stream and
// registered output beat stream, each with valid/ready flow control.
interface multi_channel_xor_cipher_if #(
    parameter int CH = 4,
    parameter int W  = 8
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] in_ch;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_ch;
    logic [W-1:0]   out_data;

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_data
    );

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/multi_channel_xor_cipher.sv
// Per-channel Galois-LFSR XOR stream cipher with serial config chain.
// Optional macro CIPHER_DBG_EN adds a registered recovered-plaintext output.
module multi_channel_xor_cipher_lane #(
    parameter int            N        = 32,
    parameter int            W        = 8,
    parameter logic [N-1:0]  TAPS_RST = '0,
    parameter logic [N-1:0]  SEED_RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         shift_in,
    input  logic         advance,
    input  logic         lock_en,
    output logic         shift_out,
    output logic         lock_err,
    output logic [W-1:0] ks
);
    logic [N-1:0] taps, state, state_step;

    // W Galois steps in one cycle; keystream bit i is the LSB before step i
    always_comb begin
        state_step = state;
        ks         = '0;
        for (int i = 0; i < W; i++) begin
            ks[i]      = state_step[0];
            state_step = (state_step >> 1) ^ (state_step[0] ? taps : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps     <= TAPS_RST;
            state    <= SEED_RST;
            lock_err <= 1'b0;
        end else if (shift_en) begin
            {taps, state} <= {shift_in, taps, state[N-1:1]};
        end else if (lock_en && state == '0) begin
            // a zero state never leaves zero; stepping it would give ks=0 anyway
            state    <= {{(N-1){1'b0}}, 1'b1};
            lock_err <= 1'b1;
        end else if (advance) begin
            state <= state_step;
        end
    end

    assign shift_out = state[0];
endmodule

module multi_channel_xor_cipher #(
    parameter int           N            = 32,
    parameter int           CH           = 4,
    parameter int           W            = 8,
    parameter logic [N-1:0] TAPS_DEFAULT = N'(32'h4800_0000),
    parameter logic [N-1:0] SEED_DEFAULT = N'(8'h55)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_en,
    input  logic                         cfg_i,
    output logic                         cfg_o,
    multi_channel_xor_cipher_if.slave    bus,
    output logic                         cfg_err,
    output logic [CH-1:0]                lock_err,
    output logic [W-1:0]                 dbg_data
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int LEN = CH * 2 * N;
    localparam int CW  = $clog2(LEN);

    typedef enum logic [1:0] {RUN, CFG, HALT} fsm_t;

    fsm_t                  fsm;
    logic [CW-1:0]         cnt;
    logic                  full_pass;
    logic [CH-1:0]         shift_out, adv;
    logic [CH-1:0][W-1:0]  ks_all;
    logic [W-1:0]          ks_sel;
    logic                  accept, lock_en;
    logic                  out_valid_q;
    logic [CHW-1:0]        out_ch_q;
    logic [W-1:0]          out_data_q;

    assign bus.in_ready = (fsm == RUN) && !cfg_en && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign lock_en      = (fsm != CFG) && !cfg_en;
    assign cfg_o        = cfg_en & shift_out[0];

    // out-of-range channel matches no lane: zero keystream, nothing advances
    always_comb begin
        ks_sel = '0;
        adv    = '0;
        for (int c = 0; c < CH; c++) begin
            if (bus.in_ch == CHW'(c)) begin
                ks_sel = ks_all[c];
                adv[c] = accept;
            end
        end
    end

    // chain order {taps[CH-1],state[CH-1],...,taps[0],state[0]}, cfg_i at MSB
    for (genvar c = 0; c < CH; c++) begin : g_lane
        logic chain_in;
        if (c == CH - 1) begin : g_top
            assign chain_in = cfg_i;
        end else begin : g_mid
            assign chain_in = shift_out[c+1];
        end

        multi_channel_xor_cipher_lane #(
            .N        (N),
            .W        (W),
            .TAPS_RST (TAPS_DEFAULT),
            .SEED_RST (SEED_DEFAULT ^ N'(c))
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .shift_en  (cfg_en),
            .shift_in  (chain_in),
            .advance   (adv[c]),
            .lock_en   (lock_en),
            .shift_out (shift_out[c]),
            .lock_err  (lock_err[c]),
            .ks        (ks_all[c])
        );
    end

    // Config FSM; counter wraps per full chain length, full_pass marks a wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= RUN;
            cnt       <= '0;
            full_pass <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (cfg_en) begin
            fsm <= CFG;
            if (cnt == CW'(LEN - 1)) begin
                cnt       <= '0;
                full_pass <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (fsm == CFG) begin
            cnt       <= '0;
            full_pass <= 1'b0;
            if (cnt == '0 && full_pass) begin
                fsm <= RUN;
            end else begin
                fsm     <= HALT;
                cfg_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= bus.in_ch;
            out_data_q  <= bus.in_data ^ ks_sel;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;

`ifdef CIPHER_DBG_EN
    logic [W-1:0] dbg_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dbg_q <= '0;
        else if (accept) dbg_q <= bus.in_data;
    end
    assign dbg_data = dbg_q;
`else
    assign dbg_data = '0;
`endif
endmodule

// File: tb/tb_multi_channel_xor_cipher.sv
// Scoreboard bench for multi_channel_xor_cipher (N=32, CH=4, W=8).
module tb_multi_channel_xor_cipher;
    localparam int N = 32;
    localparam int CH = 4;
    localparam int W = 8;
    localparam int L = CH * 2 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_en = 1'b0;
    logic cfg_i = 1'b0;
    logic cfg_o, cfg_err;
    logic [CH-1:0] lock_err;
    logic [W-1:0] dbg_data;

    multi_channel_xor_cipher_if #(.CH(CH), .W(W)) bus ();

    multi_channel_xor_cipher #(.N(N), .CH(CH), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_en   (cfg_en),
        .cfg_i    (cfg_i),
        .cfg_o    (cfg_o),
        .bus      (bus),
        .cfg_err  (cfg_err),
        .lock_err (lock_err),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] data;
        logic [W-1:0] pt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int rdy_mode = 1;  // 0 random, 1 always ready, 2 stalled

    logic [N-1:0] m_taps[CH];
    logic [N-1:0] m_st[CH];
    logic [CH-1:0] m_lock;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_taps[c] = 32'h4800_0000;
            m_st[c]   = 32'h55 ^ c;
        end
        m_lock = '0;
    endfunction

    // Keystream of one beat straight from the step definition
    function automatic logic [W-1:0] model_ks(input int ch);
        logic [W-1:0] ks = '0;
        if (ch >= CH) return '0;
        for (int i = 0; i < W; i++) begin
            ks[i] = m_st[ch][0];
            m_st[ch] = (m_st[ch] >> 1) ^ (m_st[ch][0] ? m_taps[ch] : 32'h0);
        end
        if (m_st[ch] == 0) begin
            m_st[ch] = 1;
            m_lock[ch] = 1'b1;
        end
        return ks;
    endfunction

    function automatic logic [L-1:0] model_chain();
        logic [L-1:0] v;
        for (int c = 0; c < CH; c++) begin
            v[c*2*N +: N]     = m_st[c];
            v[c*2*N + N +: N] = m_taps[c];
        end
        return v;
    endfunction

    function automatic void model_load(input logic [L-1:0] v);
        for (int c = 0; c < CH; c++) begin
            m_st[c]   = v[c*2*N +: N];
            m_taps[c] = v[c*2*N + N +: N];
        end
    endfunction

    function automatic logic [L-1:0] rand_chain();
        logic [L-1:0] v;
        for (int i = 0; i < L / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // out_ready changes just after the rising edge so it is stable at negedge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops an expectation on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_ch", bus.out_ch, e.ch);
`ifdef CIPHER_DBG_EN
                    chk("dbg_data", dbg_data, e.pt);
`endif
                end
            end
        end
    end

    task automatic send(input logic [1:0] ch, input logic [W-1:0] d, input bit force_e,
                        input logic [W-1:0] fe, output logic [W-1:0] got, output int waited);
        exp_t e;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_ch = ch;
        bus.in_data = d;
        #1;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            got = '0;
        end else begin
            got = d ^ model_ks(ch);
            e.ch = ch;
            e.data = force_e ? fe : got;
            e.pt = d;
            q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    // n shifts; rd[j] is the chain bit seen on cfg_o before shift j
    task automatic cfg_shift(input logic [L-1:0] load, input int n, output logic [L-1:0] rd);
        rd = '0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            cfg_en = 1'b1;
            cfg_i = load[j];
            #1 rd[j] = cfg_o;
        end
        @(negedge clk);
        cfg_en = 1'b0;
        cfg_i = 1'b0;
    endtask

    task automatic full_cfg(input logic [L-1:0] load, output logic [L-1:0] rd);
        logic [L-1:0] exp = model_chain();
        cfg_shift(load, L, rd);
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("rd_state%0d", c), rd[c*2*N +: N], exp[c*2*N +: N]);
            chk($sformatf("rd_taps%0d", c), rd[c*2*N + N +: N], exp[c*2*N + N +: N]);
        end
        model_load(load);
    endtask

    initial begin
        logic [L-1:0] rd, ch0, old, ld, nw;
        logic [W-1:0] got, held;
        logic [W-1:0] pt[16];
        logic [W-1:0] ct[16];
        int w;

        bus.in_valid = 1'b0;
        bus.in_ch = '0;
        bus.in_data = '0;
        model_reset();
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ch", bus.out_ch, 0);
        chk("rst_cfg_o", cfg_o, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_lock_err", lock_err, 0);
        chk("rst_dbg", dbg_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // first beat after reset on ch0, then read ch0 state back
        send(0, 8'h00, 1, 8'h55, got, w);
        drain();
        full_cfg(model_chain(), rd);
        chk("ch0_state_after_beat", rd[31:0], 32'h2FD0_0000);
        send(0, 8'hA5, 1, 8'hA5, got, w);
        drain();
        full_cfg(model_chain(), rd);
        chk("ch1_state_held", rd[1*64 +: 32], 32'h54);
        chk("ch2_state_held", rd[2*64 +: 32], 32'h57);
        chk("ch3_state_held", rd[3*64 +: 32], 32'h56);

        // backpressure: stalled output holds, no further accept
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        send(1, 8'h3C, 0, 0, held, w);
        bus.in_valid = 1'b1;
        bus.in_ch = 2'd2;
        bus.in_data = 8'h81;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_hold", bus.out_data, held);
            @(negedge clk);
        end
        rdy_mode = 1;
        send(2, 8'h81, 0, 0, got, w);
        send(3, 8'h7E, 0, 0, got, w);
        chk("b2b_wait", w, 0);
        send(0, 8'h11, 0, 0, got, w);
        chk("b2b_wait", w, 0);
        drain();
        full_cfg(model_chain(), rd);

        // randomized traffic under random backpressure
        rdy_mode = 0;
        for (int i = 0; i < 150; i++) begin
            send(2'($urandom_range(0, CH - 1)), 8'($urandom()), 0, 0, got, w);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        rdy_mode = 1;
        full_cfg(model_chain(), rd);

        // short pass lands in HALT; a full pass recovers, error stays sticky
        old = model_chain();
        ld = rand_chain();
        cfg_shift(ld, L - 1, rd);
        chk("short_rd_ch0", rd[31:0], old[31:0]);
        nw = (old >> (L - 1)) | ((ld & ({L{1'b1}} >> 1)) << 1);
        model_load(nw);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_ch = 2'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("halt_cfg_err", cfg_err, 1);
            chk("halt_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        full_cfg(model_chain(), rd);
        @(negedge clk);
        #1;
        chk("run_in_ready", bus.in_ready, 1);
        chk("run_cfg_err", cfg_err, 1);

        // zero state + zero taps on ch2: beat sees zero keystream, then reseed
        ld = model_chain();
        ld[2*64 +: 64] = '0;
        full_cfg(ld, rd);
        send(2, 8'hC3, 1, 8'hC3, got, w);
        drain();
        @(negedge clk);
        chk("lock_err", lock_err, 4'b0100);
        chk("lock_model", lock_err, m_lock);
        full_cfg(model_chain(), rd);
        chk("ch2_reseed", rd[2*64 +: 32], 32'h1);

        // round trip on ch3
        ch0 = model_chain();
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) begin
            pt[i] = 8'($urandom());
            send(3, pt[i], 0, 0, ct[i], w);
        end
        drain();
        full_cfg(ch0, rd);
        for (int i = 0; i < 16; i++) send(3, ct[i], 1, pt[i], got, w);
        drain();
        rdy_mode = 1;

        // reset in the middle of a config pass restores defaults
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            cfg_en = 1'b1;
            cfg_i = 1'($urandom());
        end
        @(negedge clk);
        rst_n = 1'b0;
        cfg_en = 1'b0;
        cfg_i = 1'b0;
        #1;
        chk("midcfg_rst_cfg_err", cfg_err, 0);
        chk("midcfg_rst_lock", lock_err, 0);
        chk("midcfg_rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        full_cfg(model_chain(), rd);
        @(negedge clk);
        chk("post_rst_cfg_err", cfg_err, 0);
        chk("cfg_o_idle", cfg_o, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
